// File: rtl/button_event_arbiter.sv
// button_event_arbiter
// Turns per-button press pulses and held levels into PRESS / LONG (and
// optionally REPEAT) events, arbitrates them round-robin into a small FIFO
// and hands them to a single valid/ready consumer.
// Optional feature macro: BUTTON_AUTOREPEAT_EN (adds periodic REPEAT events
// while a button stays held after its LONG event).
module button_event_arbiter #(
    parameter int NUM_BTN       = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 24,
    parameter int LONG_CYCLES   = 5000000,
    parameter int REPEAT_CYCLES = 1000000,
    localparam int BW = (NUM_BTN > 2) ? $clog2(NUM_BTN) : 1,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_pulse,
    input  logic [NUM_BTN-1:0] btn_level,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [BW-1:0]      ev_btn,
    output logic [1:0]         ev_kind,
    output logic [AW:0]        ev_count,
    output logic               overflow,
    input  logic               clr_ovf
);

    localparam logic [1:0] KIND_PRESS  = 2'b00;
    localparam logic [1:0] KIND_LONG   = 2'b01;
    localparam logic [1:0] KIND_REPEAT = 2'b10;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [AW:0]      FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    // Reject parameter sets the pointer arithmetic cannot handle
    if (NUM_BTN < 2 || NUM_BTN > 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("button_event_arbiter: illegal parameter set");
    end

    // Hold tracking
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] long_done_q, long_done_d;
    logic [NUM_BTN-1:0] new_press, new_long;

    // Pending requests
    logic [NUM_BTN-1:0] pend_press_q, pend_press_d;
    logic [NUM_BTN-1:0] pend_long_q, pend_long_d;
    logic [NUM_BTN-1:0] pend_any;
    logic [NUM_BTN-1:0] drop_press, drop_long;

    // Arbitration
    logic [BW-1:0]      rr_q, rr_d;
    logic               win_found;
    logic [BW-1:0]      win_btn;
    logic [1:0]         win_kind;
    logic [NUM_BTN-1:0] win_oh;
    logic               grant;
    logic [NUM_BTN-1:0] g_press, g_long;

    // Event FIFO
    logic [BW+1:0]      mem_q [FIFO_DEPTH];
    logic [BW+1:0]      wdata_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               push, pop, full;
    logic               ovf_q, ovf_d;
    logic [BW+1:0]      head;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0]   rep_cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   rep_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] pend_repeat_q, pend_repeat_d;
    logic [NUM_BTN-1:0] new_repeat, g_repeat, drop_repeat;
`endif

    // Hold counters: a pulse restarts the count, release clears it, LONG fires once per press
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i]       = cnt_q[i];
            long_done_d[i] = long_done_q[i];
            new_press[i]   = btn_pulse[i];
            new_long[i]    = 1'b0;
            if (btn_pulse[i]) begin
                cnt_d[i]       = '0;
                long_done_d[i] = 1'b0;
            end else if (btn_level[i]) begin
                if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
                if (!long_done_q[i] && cnt_q[i] == LONG_LAST) begin
                    new_long[i]    = 1'b1;
                    long_done_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i]       = '0;
                long_done_d[i] = 1'b0;
            end
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    // Repeat timers run only after LONG while the button stays held
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            rep_cnt_d[i]  = rep_cnt_q[i];
            new_repeat[i] = 1'b0;
            if (btn_pulse[i] || !btn_level[i] || !long_done_q[i]) begin
                rep_cnt_d[i] = '0;
            end else if (rep_cnt_q[i] == REP_LAST) begin
                rep_cnt_d[i]  = '0;
                new_repeat[i] = 1'b1;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + CNT_W'(1);
            end
        end
    end
`endif

    // Round-robin pick of one pending event, gated by FIFO space, plus pending/overflow update
    always_comb begin
        pop      = (count_q != '0) && ev_ready;
        full     = (count_q == FULL_CNT);
        pend_any = pend_press_q | pend_long_q;
`ifdef BUTTON_AUTOREPEAT_EN
        pend_any = pend_any | pend_repeat_q;
`endif
        win_found = 1'b0;
        win_btn   = '0;
        win_kind  = KIND_PRESS;
        win_oh    = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % NUM_BTN;
            if (!win_found && pend_any[idx]) begin
                win_found   = 1'b1;
                win_btn     = BW'(idx);
                win_oh[idx] = 1'b1;
                if (pend_press_q[idx]) begin
                    win_kind = KIND_PRESS;
                end else if (pend_long_q[idx]) begin
                    win_kind = KIND_LONG;
                end else begin
                    win_kind = KIND_REPEAT;
                end
            end
        end
        grant   = win_found && (!full || pop);
        g_press = (grant && win_kind == KIND_PRESS) ? win_oh : '0;
        g_long  = (grant && win_kind == KIND_LONG)  ? win_oh : '0;

        drop_press   = new_press & pend_press_q & ~g_press;
        drop_long    = new_long  & pend_long_q  & ~g_long;
        pend_press_d = (pend_press_q & ~g_press) | new_press;
        pend_long_d  = (pend_long_q  & ~g_long)  | new_long;
        ovf_d        = (ovf_q & ~clr_ovf) | (|drop_press) | (|drop_long);
`ifdef BUTTON_AUTOREPEAT_EN
        g_repeat      = (grant && win_kind == KIND_REPEAT) ? win_oh : '0;
        drop_repeat   = new_repeat & pend_repeat_q & ~g_repeat;
        pend_repeat_d = (pend_repeat_q & ~g_repeat) | new_repeat;
        ovf_d         = ovf_d | (|drop_repeat);
`endif

        if (grant) begin
            rr_d = (int'(win_btn) == NUM_BTN - 1) ? '0 : win_btn + BW'(1);
        end else begin
            rr_d = rr_q;
        end
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        push     = grant;
        wdata_d  = {win_btn, win_kind};
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and counter state, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            long_done_q  <= '0;
            pend_press_q <= '0;
            pend_long_q  <= '0;
            rr_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            long_done_q  <= long_done_d;
            pend_press_q <= pend_press_d;
            pend_long_q  <= pend_long_d;
            rr_q         <= rr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    // Repeat timer and pending state, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                rep_cnt_q[i] <= '0;
            end
            pend_repeat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
            pend_repeat_q <= pend_repeat_d;
        end
    end
`endif

    // FIFO storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_d;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign ev_valid = (count_q != '0);
    assign ev_btn   = ev_valid ? head[BW+1:2] : '0;
    assign ev_kind  = ev_valid ? head[1:0] : KIND_PRESS;
    assign ev_count = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: directed scenarios with
// fixed expectations plus a randomized run against a queue-based model.
module tb_button_event_arbiter;

    localparam int N     = 4;
    localparam int D     = 4;
    localparam int LONG  = 8;
    localparam int REP   = 4;
    localparam int CNT_W = 24;

    logic         clk;
    logic         reset;
    logic [N-1:0] btn_pulse;
    logic [N-1:0] btn_level;
    logic         ev_valid;
    logic         ev_ready;
    logic [1:0]   ev_btn;
    logic [1:0]   ev_kind;
    logic [2:0]   ev_count;
    logic         overflow;
    logic         clr_ovf;

    int checks;
    int failures;

    button_event_arbiter #(
        .NUM_BTN(N), .FIFO_DEPTH(D), .CNT_W(CNT_W),
        .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .reset(reset), .btn_pulse(btn_pulse), .btn_level(btn_level),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_btn(ev_btn), .ev_kind(ev_kind),
        .ev_count(ev_count), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Events are identified by age since the last press; the FIFO is a queue.
    bit m_pend [N][3];
    bit m_alive [N];
    int m_press_cyc [N];
    int m_rr;
    bit m_ovf;
    int m_cyc;
    int mq[$];       // entry = btn*4 + kind
    int got[$];      // popped button indices

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 3; k++) m_pend[i][k] = 1'b0;
            m_alive[i] = 1'b0;
            m_press_cyc[i] = 0;
        end
        m_rr = 0; m_ovf = 1'b0; m_cyc = 0;
        mq.delete();
    endtask

    task automatic model_step();
        bit pop, grant, any_drop;
        int win, wkind;
        bit ev [N][3];
        pop = (mq.size() > 0) && ev_ready;
        win = -1; wkind = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (win < 0 && (m_pend[idx][0] || m_pend[idx][1] || m_pend[idx][2])) win = idx;
        end
        grant = (win >= 0) && (mq.size() < D || pop);
        if (win >= 0) wkind = m_pend[win][0] ? 0 : (m_pend[win][1] ? 1 : 2);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 3; k++) ev[i][k] = 1'b0;
            if (btn_pulse[i]) begin
                ev[i][0] = 1'b1;
                m_alive[i] = 1'b1;
                m_press_cyc[i] = m_cyc;
            end else if (!btn_level[i]) begin
                m_alive[i] = 1'b0;
            end else if (m_alive[i]) begin
                int age;
                age = m_cyc - m_press_cyc[i];
                if (age == LONG) ev[i][1] = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                if (age > LONG && ((age - LONG) % REP) == 0) ev[i][2] = 1'b1;
`endif
            end
        end
        if (grant) m_pend[win][wkind] = 1'b0;
        any_drop = 1'b0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++)
                if (ev[i][k]) begin
                    if (m_pend[i][k]) any_drop = 1'b1;
                    m_pend[i][k] = 1'b1;
                end
        m_ovf = (m_ovf && !clr_ovf) || any_drop;
        if (pop) void'(mq.pop_front());
        if (grant) begin
            mq.push_back(win * 4 + wkind);
            m_rr = (win + 1) % N;
        end
        m_cyc++;
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b0; btn_pulse = '0; btn_level = '0; ev_ready = 1'b1; clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic pulse(input logic [N-1:0] p, input logic [N-1:0] lvl);
        btn_pulse = p; btn_level = lvl;
        tick();
        btn_pulse = '0;
    endtask

    task automatic collect_pops(input int cycles);
        got.delete();
        for (int c = 0; c < cycles; c++) begin
            if (ev_valid && ev_ready) got.push_back(int'(ev_btn));
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ev_valid); end
        checks++; if (ev_btn !== 2'd0) begin failures++; $display("FAIL reset_btn got=%0d exp=0", ev_btn); end
        checks++; if (ev_kind !== 2'b00) begin failures++; $display("FAIL reset_kind got=%0d exp=0", ev_kind); end
        checks++; if (ev_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ev_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
    endtask

    task automatic test_single_press();
        apply_reset();
        pulse(4'b0100, 4'b0100);
        for (int n = 1; n <= 16; n++) begin
            logic exp_v;
            exp_v = (n == 2);
            checks++; if (ev_valid !== exp_v) begin failures++; $display("FAIL single_valid n=%0d got=%0b exp=%0b", n, ev_valid, exp_v); end
            if (exp_v) begin
                checks++; if (ev_btn !== 2'd2 || ev_kind !== 2'b00) begin failures++; $display("FAIL single_event got=%0d/%0d exp=2/0", ev_btn, ev_kind); end
            end
            if (n == 3) btn_level = '0;
            tick();
        end
        checks++; if (ev_count !== 3'd0) begin failures++; $display("FAIL single_count_end got=%0d exp=0", ev_count); end
    endtask

    task automatic test_long_hold();
        apply_reset();
        pulse(4'b0010, 4'b0010);
        for (int n = 1; n <= 30; n++) begin
            logic exp_v;
            logic [1:0] exp_k;
            exp_v = 1'b0; exp_k = 2'b00;
            if (n == 2) exp_v = 1'b1;
            if (n == 10) begin exp_v = 1'b1; exp_k = 2'b01; end
`ifdef BUTTON_AUTOREPEAT_EN
            if (n == 14 || n == 18 || n == 22) begin exp_v = 1'b1; exp_k = 2'b10; end
`endif
            checks++; if (ev_valid !== exp_v) begin failures++; $display("FAIL long_valid n=%0d got=%0b exp=%0b", n, ev_valid, exp_v); end
            if (exp_v) begin
                checks++; if (ev_btn !== 2'd1 || ev_kind !== exp_k) begin failures++; $display("FAIL long_event n=%0d got=%0d/%0d exp=1/%0d", n, ev_btn, ev_kind, exp_k); end
            end
            if (n == 21) btn_level = '0;
            tick();
        end
    endtask

    task automatic test_simultaneous();
        int exp_a[4] = '{0, 1, 2, 3};
        int exp_b[4] = '{2, 3, 0, 1};
        apply_reset();
        pulse(4'b1111, 4'b0000);
        collect_pops(12);
        checks++; if (got.size() != 4) begin failures++; $display("FAIL simul_a_size got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] != exp_a[i]) begin failures++; $display("FAIL simul_a_order i=%0d got=%0d exp=%0d", i, got[i], exp_a[i]); end
        end
        apply_reset();
        pulse(4'b0010, 4'b0000);
        repeat (6) tick();
        pulse(4'b1111, 4'b0000);
        collect_pops(12);
        checks++; if (got.size() != 4) begin failures++; $display("FAIL simul_b_size got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] != exp_b[i]) begin failures++; $display("FAIL simul_b_order i=%0d got=%0d exp=%0d", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_backpressure();
        int exp_o[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        ev_ready = 1'b0;
        pulse(4'b1111, 4'b0000);
        repeat (6) tick();
        checks++; if (ev_count !== 3'd4) begin failures++; $display("FAIL bp_full got=%0d exp=4", ev_count); end
        pulse(4'b0001, 4'b0000);
        tick();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bp_first_pending_ovf got=%0b exp=0", overflow); end
        pulse(4'b0001, 4'b0000);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_drop_ovf got=%0b exp=1", overflow); end
        checks++; if (ev_count !== 3'd4) begin failures++; $display("FAIL bp_count_held got=%0d exp=4", ev_count); end
        ev_ready = 1'b1;
        collect_pops(12);
        checks++; if (got.size() != 5) begin failures++; $display("FAIL bp_pops got=%0d exp=5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++; if (got[i] != exp_o[i]) begin failures++; $display("FAIL bp_order i=%0d got=%0d exp=%0d", i, got[i], exp_o[i]); end
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_ovf_sticky got=%0b exp=1", overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bp_ovf_clear got=%0b exp=0", overflow); end
    endtask

    task automatic test_full_pop();
        int exp_o[4] = '{1, 2, 3, 3};
        apply_reset();
        ev_ready = 1'b0;
        pulse(4'b1111, 4'b0000);
        repeat (5) tick();
        pulse(4'b1000, 4'b0000);
        tick();
        checks++; if (ev_count !== 3'd4 || ev_btn !== 2'd0) begin failures++; $display("FAIL fp_before got=%0d/%0d exp=4/0", ev_count, ev_btn); end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checks++; if (ev_count !== 3'd4) begin failures++; $display("FAIL fp_count_same got=%0d exp=4", ev_count); end
        checks++; if (ev_btn !== 2'd1 || ev_valid !== 1'b1) begin failures++; $display("FAIL fp_head got=%0d exp=1", ev_btn); end
        repeat (2) tick();
        checks++; if (ev_btn !== 2'd1 || ev_kind !== 2'b00) begin failures++; $display("FAIL fp_head_stable got=%0d/%0d exp=1/0", ev_btn, ev_kind); end
        ev_ready = 1'b1;
        collect_pops(10);
        checks++; if (got.size() != 4) begin failures++; $display("FAIL fp_pops got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] != exp_o[i]) begin failures++; $display("FAIL fp_order i=%0d got=%0d exp=%0d", i, got[i], exp_o[i]); end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        ev_ready = 1'b0;
        pulse(4'b0111, 4'b0000);
        repeat (4) tick();
        checks++; if (ev_count !== 3'd3) begin failures++; $display("FAIL ar_pre_count got=%0d exp=3", ev_count); end
        #2 reset = 1'b0;
        #1;
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%0b exp=0", ev_valid); end
        checks++; if (ev_count !== 3'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", ev_count); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        ev_ready = 1'b1;
        pulse(4'b0100, 4'b0100);
        btn_level = '0;
        for (int n = 1; n <= 4; n++) begin
            checks++; if (ev_valid !== (n == 2)) begin failures++; $display("FAIL ar_press_valid n=%0d got=%0b", n, ev_valid); end
            if (n == 2) begin
                checks++; if (ev_btn !== 2'd2 || ev_kind !== 2'b00) begin failures++; $display("FAIL ar_press_event got=%0d/%0d exp=2/0", ev_btn, ev_kind); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        int hold_left [N];
        apply_reset();
        for (int i = 0; i < N; i++) hold_left[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            checks++; if (ev_count !== 3'(mq.size())) begin failures++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, ev_count, mq.size()); end
            checks++; if (ev_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rand_valid c=%0d got=%0b exp=%0b", c, ev_valid, mq.size() > 0); end
            if (mq.size() > 0) begin
                checks++;
                if (ev_btn !== 2'(mq[0] / 4) || ev_kind !== 2'(mq[0] % 4)) begin
                    failures++; $display("FAIL rand_head c=%0d got=%0d/%0d exp=%0d/%0d", c, ev_btn, ev_kind, mq[0] / 4, mq[0] % 4);
                end
            end
            checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rand_ovf c=%0d got=%0b exp=%0b", c, overflow, m_ovf); end
            for (int i = 0; i < N; i++) begin
                btn_pulse[i] = 1'b0;
                if (hold_left[i] > 0) begin
                    btn_level[i] = 1'b1;
                    hold_left[i]--;
                    if ($urandom_range(0, 29) == 0) btn_pulse[i] = 1'b1;
                end else if ($urandom_range(0, 9) == 0) begin
                    btn_pulse[i] = 1'b1;
                    btn_level[i] = 1'b1;
                    hold_left[i] = $urandom_range(0, 28);
                end else begin
                    btn_level[i] = 1'b0;
                    if ($urandom_range(0, 39) == 0) btn_pulse[i] = 1'b1;
                end
            end
            if (((c / 100) % 2) == 0) ev_ready = ($urandom_range(0, 3) != 0);
            else ev_ready = ($urandom_range(0, 5) == 0);
            clr_ovf = ($urandom_range(0, 24) == 0);
            tick();
        end
        btn_pulse = '0; btn_level = '0; clr_ovf = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; btn_pulse = '0; btn_level = '0; ev_ready = 1'b1; clr_ovf = 1'b0;
        model_reset();
        test_reset();
        test_single_press();
        test_long_hold();
        test_simultaneous();
        test_backpressure();
        test_full_pop();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
